// File: rtl/vga_mode_scheduler_if.sv
// Screen-mode request/apply bundle between the CPU-side mode register, the sync
// generator and the pixel path; FRAME_CNT_W sizes the frame counter.
interface vga_mode_scheduler_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   iVS;
  logic                   req_valid;
  logic [31:0]            req_mode;
  logic                   req_ready;
  logic [31:0]            screenMode_out;
  logic                   force_blank;
  logic                   mode_changed;
  logic                   busy;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output iVS,
    output req_valid,
    output req_mode,
    input  req_ready,
    input  screenMode_out,
    input  force_blank,
    input  mode_changed,
    input  busy,
    input  frame_count
  );

  modport slave (
    input  iVS,
    input  req_valid,
    input  req_mode,
    output req_ready,
    output screenMode_out,
    output force_blank,
    output mode_changed,
    output busy,
    output frame_count
  );
endinterface

// File: rtl/vga_mode_scheduler.sv
// Defers screen-mode changes to vsync frame boundaries, inserting BLANK_FRAMES black
// frames before a mode switch; one request in flight, req_ready low while busy.
module vga_mode_scheduler #(
  parameter int BLANK_FRAMES = 2,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                 iVGA_CLK,
  input  logic                 reset,
  vga_mode_scheduler_if.slave  bus
);

  localparam int BCW = (BLANK_FRAMES > 2) ? $clog2(BLANK_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_META = 2'd1,
    WAIT_VS   = 2'd2,
    BLANK     = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_vs_q;
  logic [31:0]            r_pending;
  logic [BCW-1:0]         r_blank_cnt;
  logic [31:0]            r_screen_mode;
  logic                   r_force_blank;
  logic                   r_mode_changed;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic w_frame_tick;
  logic w_accept;

  // iVS is active-low, so the boundary is the first cycle it samples low.
  assign w_frame_tick = r_vs_q & ~bus.iVS;
  assign w_accept     = bus.req_valid && (r_state == IDLE);

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_vs_q         <= 1'b1;
      r_pending      <= '0;
      r_blank_cnt    <= '0;
      r_screen_mode  <= '0;
      r_force_blank  <= 1'b0;
      r_mode_changed <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_vs_q         <= bus.iVS;
      r_mode_changed <= 1'b0;
      if (w_frame_tick) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          // A request landing on a tick cycle deliberately waits for the next tick.
          if (w_accept) begin
            r_pending <= bus.req_mode;
            if (bus.req_mode[31:29] == r_screen_mode[31:29]) begin
              r_state <= WAIT_META;
            end else begin
              r_state <= WAIT_VS;
            end
          end
        end

        WAIT_META: begin
          if (w_frame_tick) begin
            r_screen_mode  <= r_pending;
            r_mode_changed <= 1'b1;
            r_state        <= IDLE;
          end
        end

        WAIT_VS: begin
          if (w_frame_tick) begin
            if (BLANK_FRAMES == 0) begin
              r_screen_mode  <= r_pending;
              r_mode_changed <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_force_blank <= 1'b1;
              r_blank_cnt   <= BCW'(BLANK_FRAMES - 1);
              r_state       <= BLANK;
            end
          end
        end

        BLANK: begin
          if (w_frame_tick) begin
            if (r_blank_cnt == '0) begin
              r_screen_mode  <= r_pending;
              r_force_blank  <= 1'b0;
              r_mode_changed <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_blank_cnt <= r_blank_cnt - BCW'(1);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (r_state == IDLE);
  assign bus.busy           = (r_state != IDLE);
  assign bus.screenMode_out = r_screen_mode;
  assign bus.force_blank    = r_force_blank;
  assign bus.mode_changed   = r_mode_changed;
  assign bus.frame_count    = r_frame_count;

endmodule

// File: tb/tb_vga_mode_scheduler.sv
// Scoreboard bench: each issued request pushes its expected applied word and frame count,
// and monitors pop on every mode_changed pulse.
module tb_vga_mode_scheduler;

  logic clk;
  logic rst;

  vga_mode_scheduler_if #(.FRAME_CNT_W(16)) bus_a ();
  vga_mode_scheduler_if #(.FRAME_CNT_W(4))  bus_b ();

  vga_mode_scheduler #(.BLANK_FRAMES(2), .FRAME_CNT_W(16)) u_dut_a (
    .iVGA_CLK (clk),
    .reset    (rst),
    .bus      (bus_a.slave)
  );

  vga_mode_scheduler #(.BLANK_FRAMES(0), .FRAME_CNT_W(4)) u_dut_b (
    .iVGA_CLK (clk),
    .reset    (rst),
    .bus      (bus_b.slave)
  );

  typedef struct {
    logic [31:0] mode;
    logic [15:0] fc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every mode_changed cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && bus_a.mode_changed) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_mode_changed", 64'(bus_a.screenMode_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_screenMode_at_apply", 64'(bus_a.screenMode_out), 64'(e.mode));
        chk("a_frame_count_at_apply", 64'(bus_a.frame_count), 64'(e.fc));
        chk("a_force_blank_at_apply", 64'(bus_a.force_blank), 64'd0);
      end
    end
    if (!rst && bus_b.mode_changed) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_mode_changed", 64'(bus_b.screenMode_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_screenMode_at_apply", 64'(bus_b.screenMode_out), 64'(e.mode));
        chk("b_frame_count_at_apply", 64'(bus_b.frame_count), 64'(e.fc[3:0]));
        chk("b_force_blank_at_apply", 64'(bus_b.force_blank), 64'd0);
      end
    end
  end

  // Handshake on the selected instance; called at posedge+1 with iVS high.
  task automatic send(input int sel, input logic [31:0] m);
    int n;
    n = 0;
    if (sel == 0) begin
      bus_a.req_valid = 1'b1;
      bus_a.req_mode  = m;
      while (!bus_a.req_ready && n < 50) begin step(); n++; end
    end else begin
      bus_b.req_valid = 1'b1;
      bus_b.req_mode  = m;
      while (!bus_b.req_ready && n < 50) begin step(); n++; end
    end
    if (n >= 50) chk("send_ready_timeout", 64'(n), 64'd0);
    step();
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
  endtask

  // One frame boundary; force_blank of instance A is checked right after the tick edge.
  task automatic frame_chk(input string name, input logic exp_fb);
    bus_a.iVS = 1'b0;
    bus_b.iVS = 1'b0;
    step();
    chk(name, 64'(bus_a.force_blank), 64'(exp_fb));
    step();
    bus_a.iVS = 1'b1;
    bus_b.iVS = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.iVS = 1'b1;       bus_b.iVS = 1'b1;
    bus_a.req_valid = 1'b0; bus_b.req_valid = 1'b0;
    bus_a.req_mode = '0;    bus_b.req_mode = '0;
    repeat (3) step();
    chk("rst_force_blank_in_reset", 64'(bus_a.force_blank), 64'd0);
    chk("rst_req_ready_in_reset", 64'(bus_a.req_ready), 64'd1);
    rst = 1'b0;
    repeat (10) step();
    chk("rst_screenMode", 64'(bus_a.screenMode_out), 64'd0);
    chk("rst_force_blank", 64'(bus_a.force_blank), 64'd0);
    chk("rst_mode_changed", 64'(bus_a.mode_changed), 64'd0);
    chk("rst_frame_count", 64'(bus_a.frame_count), 64'd0);
    chk("rst_req_ready", 64'(bus_a.req_ready), 64'd1);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_b_frame_count", 64'(bus_b.frame_count), 64'd0);

    // Metadata-only update: applied at tick 1 without blanking.
    q_a.push_back('{mode: 32'h0000_0005, fc: 16'd1});
    send(0, 32'h0000_0005);
    chk("meta_busy", 64'(bus_a.busy), 64'd1);
    chk("meta_ready_low", 64'(bus_a.req_ready), 64'd0);
    frame_chk("meta_tick1_force_blank", 1'b0);
    chk("meta_ready_after", 64'(bus_a.req_ready), 64'd1);
    chk("meta_screenMode_held", 64'(bus_a.screenMode_out), 64'h0000_0005);

    // Mode change: black for ticks 2..3, applied at tick 4.
    q_a.push_back('{mode: 32'h2000_0000, fc: 16'd4});
    send(0, 32'h2000_0000);
    frame_chk("mode_tick2_force_blank", 1'b1);
    chk("mode_old_word_during_blank", 64'(bus_a.screenMode_out), 64'h0000_0005);
    frame_chk("mode_tick3_force_blank", 1'b1);
    frame_chk("mode_tick4_force_blank", 1'b0);
    chk("mode_frame_count", 64'(bus_a.frame_count), 64'd4);

    // Tick collision: accepted on tick 5, applied on tick 6.
    bus_a.req_valid = 1'b1;
    bus_a.req_mode  = 32'h2000_0007;
    bus_a.iVS = 1'b0; bus_b.iVS = 1'b0;
    step();
    bus_a.req_valid = 1'b0;
    chk("coll_busy", 64'(bus_a.busy), 64'd1);
    chk("coll_not_applied", 64'(bus_a.screenMode_out), 64'h2000_0000);
    q_a.push_back('{mode: 32'h2000_0007, fc: 16'd6});
    step();
    bus_a.iVS = 1'b1; bus_b.iVS = 1'b1;
    repeat (3) step();
    frame_chk("coll_tick6_force_blank", 1'b0);

    // Backpressure: second request held during blanking, accepted after apply at tick 9.
    q_a.push_back('{mode: 32'h4000_0000, fc: 16'd9});
    send(0, 32'h4000_0000);
    bus_a.req_valid = 1'b1;
    bus_a.req_mode  = 32'h4000_0003;
    frame_chk("bp_tick7_force_blank", 1'b1);
    chk("bp_ready_tick7", 64'(bus_a.req_ready), 64'd0);
    frame_chk("bp_tick8_force_blank", 1'b1);
    chk("bp_ready_tick8", 64'(bus_a.req_ready), 64'd0);
    bus_a.iVS = 1'b0; bus_b.iVS = 1'b0;
    step();
    chk("bp_ready_after_apply", 64'(bus_a.req_ready), 64'd1);
    q_a.push_back('{mode: 32'h4000_0003, fc: 16'd10});
    step();
    bus_a.req_valid = 1'b0;
    chk("bp_second_accepted", 64'(bus_a.busy), 64'd1);
    bus_a.iVS = 1'b1; bus_b.iVS = 1'b1;
    repeat (3) step();
    frame_chk("bp_tick10_force_blank", 1'b0);
    chk("bp_idle_after", 64'(bus_a.busy), 64'd0);

    // Reset during BLANK: outputs return to reset values without a clock edge.
    send(0, 32'h6000_0000);
    frame_chk("rstmid_tick11_force_blank", 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_force_blank", 64'(bus_a.force_blank), 64'd0);
    chk("rstmid_screenMode", 64'(bus_a.screenMode_out), 64'd0);
    chk("rstmid_frame_count", 64'(bus_a.frame_count), 64'd0);
    chk("rstmid_busy", 64'(bus_a.busy), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // BLANK_FRAMES=0 instance: direct apply at tick 1, then counter wrap at 16 ticks.
    q_b.push_back('{mode: 32'h2000_0001, fc: 16'd1});
    send(1, 32'h2000_0001);
    frame_chk("wrap_tick1_a_force_blank", 1'b0);
    chk("b_force_blank_no_blank", 64'(bus_b.force_blank), 64'd0);
    chk("b_screenMode", 64'(bus_b.screenMode_out), 64'h2000_0001);
    for (int i = 2; i <= 15; i++) frame_chk("wrap_a_force_blank", 1'b0);
    chk("wrap_b_fc_15", 64'(bus_b.frame_count), 64'd15);
    frame_chk("wrap_tick16_a_force_blank", 1'b0);
    chk("wrap_b_fc_0", 64'(bus_b.frame_count), 64'd0);
    chk("wrap_a_fc_16", 64'(bus_a.frame_count), 64'd16);

    repeat (4) step();
    chk("q_a_drained", 64'(q_a.size()), 64'd0);
    chk("q_b_drained", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
